uart_rx_buffer: RTL and testbench
=================================

Name: uart_rx_buffer

Overview:
- Receive-side byte FIFO between the UART receiver (serial-to-byte) and the load-path encoder that returns UART status/data to the register file.
- Buffers received bytes and presents the head byte as DataOut with DataOutValid.
- Pops exactly one byte per CPU load from the receive-data address (32'h8000000c), however many cycles memRd stays asserted.
- Flags bytes lost when the buffer is full.

Parameters:
- DEPTH, 8, number of byte entries; power of two, 2..256.
- ADDR_W, 3, pointer width, log2(DEPTH).
- RX_DATA_ADDR, 32'h8000000c, load address that consumes the head byte.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  rx_data valid this cycle.
- rx_ready  out  1  buffer can accept a byte this cycle.
- addr  in  32  CPU memory address, same bus as the encoder.
- memRd  in  1  CPU load strobe.
- flush  in  1  synchronous clear of contents and overflow flag.
- DataOut  out  8  head byte, to encoder.
- DataOutValid  out  1  buffer non-empty, to encoder.
- count  out  ADDR_W+1  bytes held, 0..DEPTH.
- overflow  out  1  sticky: at least one byte dropped.

Behaviour:
- Reset, async on reset_n low, state:
  - rd_ptr = 0, wr_ptr = 0, count = 0.
  - overflow = 0, rd_seen = 0.
  - DataOutValid = 0, rx_ready = 1.
  - DataOut = 8'h00 (storage array need not be reset).
- Reset mid-operation discards all buffered bytes. The first byte after release is accepted normally.
- Storage: circular buffer of DEPTH bytes, registered pointers, wrap from DEPTH-1 to 0.
- Outputs:
  - DataOut = mem[rd_ptr] when count != 0, else 8'h00.
  - DataOutValid = (count != 0).
  - Both depend on registered state only: no combinational path from rx_* to DataOut.
- Read detect:
  - rd_hit = memRd && (addr == RX_DATA_ADDR).
  - rd_seen <= rd_hit each cycle.
  - pop = rd_hit && !rd_seen && DataOutValid. Only the first cycle of a held load pops.
- Read timing: the encoder samples DataOut combinationally during the pop cycle. The head advances at that cycle's rising edge, so the next load sees the next byte.
- Push: push = rx_valid && rx_ready. Writes mem[wr_ptr], then wr_ptr++.
- rx_ready = (count != DEPTH) || pop. This is a combinational path from memRd/addr.
- Count: push&&!pop +1; pop&&!push -1; both or neither, unchanged.
- Simultaneous events:
  - Full + pop + rx_valid: byte accepted, count stays DEPTH, no overflow.
  - Empty + rx_valid + rd_hit: byte written, no pop (no bypass). DataOutValid rises next cycle. rd_seen is set, so that held load does not pop the new byte.
- Overflow: rx_valid && !rx_ready sets overflow = 1 and drops the byte; pointers unchanged. Cleared only by reset or flush.
- Flush (sync) clears pointers, count and overflow. Flush has priority over push/pop that cycle, and an incoming byte that cycle is discarded without setting overflow.
- Load from any other address, or rd_hit while empty: no state change except rd_seen.
- Latency: byte accepted at edge N is visible on DataOut/DataOutValid after edge N (one cycle).

Decomposition:
- Shared package (uart_pkg): UART MMIO address constants:
  - UART_CTRL_ADDR 32'h80000000
  - UART_RXVALID_ADDR 32'h80000004
  - UART_TXDATA_ADDR 32'h80000008
  - UART_RXDATA_ADDR 32'h8000000c
- The encoder and this block both import these constants.
- One natural sub-module, byte_fifo: generic DEPTH x 8 circular buffer with push/pop/count/full/empty.
- uart_rx_buffer wraps byte_fifo and adds read-edge detection, address decode and overflow flag.

Test Plan:
- Reset: hold reset_n=0 mid-stream with 3 bytes queued -> count=0, DataOutValid=0, DataOut=00, overflow=0, rx_ready=1 immediately and after release.
- Order: push 8'h41, 8'h42, 8'h43; three single-cycle loads at 32'h8000000c -> DataOut seen 41, 42, 43 in the pop cycles; count 3->0; DataOutValid=0 after.
- Held load: memRd held 4 cycles at 32'h8000000c with bytes 55, 66 queued -> exactly one pop; DataOut shows 66 afterwards; count=1.
- Full/overflow (DEPTH=8): push 8 bytes 00..07 -> rx_ready=0. Ninth byte AA with no read -> dropped, overflow=1, count=8. Then a load plus byte BB same cycle -> 00 returned, BB accepted, count=8. Drain -> 01..07, BB.
- Wrap: 20 interleaved push/pop cycles across pointer wrap -> data order preserved, count never exceeds DEPTH.
- Flush and simultaneous events:
  - Flush with 5 bytes queued and rx_valid=1 -> count=0, overflow=0, byte discarded.
  - Empty buffer, rx_valid with load same cycle -> no pop; DataOutValid=1 next cycle with that byte.

Source files
------------

// File: rtl/uart_pkg.sv
// UART MMIO address map shared by the load-path encoder and the receive buffer.
package uart_pkg;

  localparam logic [31:0] UART_CTRL_ADDR    = 32'h8000_0000;
  localparam logic [31:0] UART_RXVALID_ADDR = 32'h8000_0004;
  localparam logic [31:0] UART_TXDATA_ADDR  = 32'h8000_0008;
  localparam logic [31:0] UART_RXDATA_ADDR  = 32'h8000_000c;

endpackage

// File: rtl/byte_fifo.sv
// Generic DEPTH x 8 circular byte buffer with registered pointers and occupancy count.
module byte_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [7:0]        wrData,
  output logic [7:0]        headData,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rdPtr;
  logic [ADDR_W-1:0] wrPtr;
  logic              doPush;
  logic              doPop;

  // The caller only pushes when not full or popping in the same cycle.
  assign doPush = push && !flush;
  assign doPop  = pop && !empty && !flush;

  // NOTE: storage has no reset; the count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  // DEPTH is a power of two, so pointer increment wraps DEPTH-1 -> 0 for free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + ADDR_W'(1);
      if (doPop)  rdPtr <= rdPtr + ADDR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign full     = (count == (ADDR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign headData = empty ? 8'h00 : mem[rdPtr];

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive byte buffer between the UART receiver and the load-path encoder:
// one pop per CPU load of the RX data address, sticky overflow on dropped bytes.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int          DEPTH        = 8,
  parameter int          ADDR_W       = 3,
  parameter logic [31:0] RX_DATA_ADDR = UART_RXDATA_ADDR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [31:0]       addr,
  input  logic              memRd,
  input  logic              flush,
  output logic [7:0]        DataOut,
  output logic              DataOutValid,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  logic rdHit;
  logic rdSeen;
  logic pop;
  logic push;
  logic full;
  logic empty;

  // A held load pops only on its first cycle; rdSeen remembers the previous cycle's hit.
  assign rdHit        = memRd && (addr == RX_DATA_ADDR);
  assign DataOutValid = !empty;
  assign pop          = rdHit && !rdSeen && DataOutValid;
  assign rx_ready     = !full || pop;
  assign push         = rx_valid && rx_ready;

  byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .push     (push),
    .pop      (pop),
    .wrData   (rx_data),
    .headData (DataOut),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdSeen   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rdSeen <= rdHit;
      // A byte arriving during flush is discarded silently, not counted as a drop.
      if (flush)                      overflow <= 1'b0;
      else if (rx_valid && !rx_ready) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed self-checking bench for uart_rx_buffer (DEPTH = 8).
module tb_uart_rx_buffer;
  import uart_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] addr;
  logic        memRd;
  logic        flush;
  logic [7:0]  DataOut;
  logic        DataOutValid;
  logic [3:0]  count;
  logic        overflow;

  int nChecks = 0;
  int nPass   = 0;

  uart_rx_buffer #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .addr         (addr),
    .memRd        (memRd),
    .flush        (flush),
    .DataOut      (DataOut),
    .DataOutValid (DataOutValid),
    .count        (count),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs change 1ns after a rising edge; combinational outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushByte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Single-cycle load of the RX data address followed by an idle cycle.
  task automatic loadByte(input string tag, input logic [7:0] exp);
    addr  = UART_RXDATA_ADDR;
    memRd = 1'b1;
    #1;
    check(tag, DataOut, exp);
    tick();
    memRd = 1'b0;
    tick();
  endtask

  logic [7:0] q[$];
  logic [7:0] b;
  logic       doLoad;
  logic       doPush;
  logic       expPop;
  logic       expReady;

  initial begin
    reset_n  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    addr     = 32'h0;
    memRd    = 1'b0;
    flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    // Reset mid-stream with three bytes queued
    pushByte(8'h11); pushByte(8'h22); pushByte(8'h33);
    check("pre_reset_count", count, 3);
    reset_n = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_valid", DataOutValid, 0);
    check("rst_data", DataOut, 8'h00);
    check("rst_overflow", overflow, 0);
    check("rst_ready", rx_ready, 1);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_count", count, 0);
    check("post_rst_valid", DataOutValid, 0);
    check("post_rst_ready", rx_ready, 1);

    // Ordering and one-cycle latency
    pushByte(8'h41);
    check("lat_valid", DataOutValid, 1);
    check("lat_data", DataOut, 8'h41);
    pushByte(8'h42); pushByte(8'h43);
    check("order_count3", count, 3);
    loadByte("order_41", 8'h41);
    loadByte("order_42", 8'h42);
    loadByte("order_43", 8'h43);
    check("order_count0", count, 0);
    check("order_valid0", DataOutValid, 0);
    check("order_data0", DataOut, 8'h00);

    // Held load pops exactly once
    pushByte(8'h55); pushByte(8'h66);
    addr  = UART_RXDATA_ADDR;
    memRd = 1'b1;
    #1;
    check("held_first", DataOut, 8'h55);
    repeat (4) tick();
    memRd = 1'b0;
    tick();
    check("held_count", count, 1);
    check("held_data", DataOut, 8'h66);

    // Load of another address leaves the buffer alone
    addr  = UART_CTRL_ADDR;
    memRd = 1'b1;
    tick();
    memRd = 1'b0;
    tick();
    check("other_addr_count", count, 1);
    loadByte("held_drain_66", 8'h66);

    // Fill, overflow, then pop and push together while full
    for (int i = 0; i < 8; i++) pushByte(8'(i));
    check("full_count", count, 8);
    check("full_ready", rx_ready, 0);
    check("full_overflow0", overflow, 0);
    pushByte(8'hAA);
    check("ovf_flag", overflow, 1);
    check("ovf_count", count, 8);
    check("ovf_head", DataOut, 8'h00);
    rx_data  = 8'hBB;
    rx_valid = 1'b1;
    addr     = UART_RXDATA_ADDR;
    memRd    = 1'b1;
    #1;
    check("fullpop_ready", rx_ready, 1);
    check("fullpop_data", DataOut, 8'h00);
    tick();
    rx_valid = 1'b0;
    memRd    = 1'b0;
    tick();
    check("fullpop_count", count, 8);
    check("fullpop_overflow", overflow, 1);
    for (int i = 1; i < 8; i++) loadByte($sformatf("drain_%0d", i), 8'(i));
    loadByte("drain_bb", 8'hBB);
    check("drain_count", count, 0);

    // Interleaved push/pop across the pointer wrap, against a queue model
    q.delete();
    for (int i = 0; i < 20; i++) begin
      doPush   = (i % 3) != 2;
      doLoad   = (i % 3) == 1;
      expPop   = doLoad && (q.size() > 0);
      expReady = (q.size() < 8) || expPop;
      rx_data  = 8'h10 + 8'(i);
      rx_valid = doPush;
      addr     = UART_RXDATA_ADDR;
      memRd    = doLoad;
      #1;
      check($sformatf("wrap_ready_%0d", i), rx_ready, expReady);
      if (expPop) begin
        check($sformatf("wrap_data_%0d", i), DataOut, q[0]);
        void'(q.pop_front());
      end
      if (doPush && expReady) q.push_back(8'h10 + 8'(i));
      tick();
      rx_valid = 1'b0;
      memRd    = 1'b0;
      check($sformatf("wrap_count_%0d", i), count, q.size());
    end
    tick();
    while (q.size() > 2) begin
      b = q.pop_front();
      loadByte("wrap_drain", b);
    end

    // Flush with five bytes queued (two left from the wrap test) and a byte arriving
    pushByte(8'hC0); pushByte(8'hC1); pushByte(8'hC2);
    check("flush_pre_count", count, 5);
    rx_data  = 8'hEE;
    rx_valid = 1'b1;
    flush    = 1'b1;
    tick();
    rx_valid = 1'b0;
    flush    = 1'b0;
    check("flush_count", count, 0);
    check("flush_overflow", overflow, 0);
    check("flush_valid", DataOutValid, 0);
    check("flush_data", DataOut, 8'h00);

    // Empty buffer: arriving byte and load in the same cycle, load then held
    rx_data  = 8'hC3;
    rx_valid = 1'b1;
    addr     = UART_RXDATA_ADDR;
    memRd    = 1'b1;
    #1;
    check("bypass_valid0", DataOutValid, 0);
    tick();
    rx_valid = 1'b0;
    check("bypass_valid1", DataOutValid, 1);
    check("bypass_data", DataOut, 8'hC3);
    tick();
    memRd = 1'b0;
    check("bypass_held_count", count, 1);
    tick();
    loadByte("bypass_drain", 8'hC3);
    check("final_count", count, 0);
    check("final_overflow", overflow, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
